pipe_share_arbiter: RTL
=======================

PIPE_SHARE_ARBITER -- requirements
Module: pipe_share_arbiter

Interface
REQ-001 Parameter Pra_Width, default 8: data width of the shared fixed-latency pipeline.
REQ-002 Parameter Pra_Delay, default 4, range 1..32: latency of the shared pipeline, in cycles.
REQ-003 Parameter Pra_Req, default 4, range 2..8: number of requesters.
REQ-004 i_clk  input  1  clock; all logic is on the rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_enable  input  1  when high, grants are allowed; when low, no new grants are issued.
REQ-007 i_req  input  Pra_Req  per-requester request, level-held until granted.
REQ-008 i_req_data  input  Pra_Req*Pra_Width  per-requester payload; requester k uses slice [k*Pra_Width +: Pra_Width].
REQ-009 o_gnt  output  Pra_Req  one-hot grant, registered; a high bit means the payload was taken this cycle.
REQ-010 o_pipe_valid  output  1  registered issue strobe to the shared pipeline.
REQ-011 o_pipe_data  output  Pra_Width  registered payload to the shared pipeline.
REQ-012 i_pipe_data  input  Pra_Width  pipeline result, valid exactly Pra_Delay cycles after the matching o_pipe_valid.
REQ-013 o_rsp_valid  output  1  response strobe.
REQ-014 o_rsp_id  output  $clog2(Pra_Req)  index of the requester that owns the response.
REQ-015 o_rsp_data  output  Pra_Width  response payload, equal to i_pipe_data.
REQ-016 o_busy  output  1  high while any issue is in flight.
REQ-017 o_issue_cnt  output  16  count of issues, wrapping.

Function
REQ-018 Arbitration shall be round-robin: the search starts at (last granted index + 1) mod Pra_Req, and the first requester with i_req high wins.
REQ-019 At most one grant shall be issued per cycle; the pipeline never stalls, so throughput is one issue per cycle.
REQ-020 In a grant cycle, the block shall register o_gnt, o_pipe_valid=1, and o_pipe_data = winner payload, so all three are visible in the cycle after i_req is sampled.
REQ-021 In a no-grant cycle, o_gnt shall be 0 and o_pipe_valid shall be 0; o_pipe_data shall hold its previous value.
REQ-022 After a grant to k, requester k shall drop or change i_req in the cycle o_gnt[k] is seen. A held request counts as a new request.
REQ-023 The block shall keep a tag shift line of depth Pra_Delay carrying {valid, id}, loaded in step with o_pipe_valid.
REQ-024 The tag leaving the tag line shall be aligned so that o_rsp_valid/o_rsp_id assert in the same cycle i_pipe_data is valid, i.e. Pra_Delay cycles after o_pipe_valid.
REQ-025 o_rsp_data shall be a combinational pass-through of i_pipe_data; it is qualified only by o_rsp_valid.
REQ-026 o_busy shall equal the OR of all valid bits in the tag line, ORed with o_pipe_valid.
REQ-027 o_issue_cnt shall increment by 1 per o_pipe_valid and wrap from 0xFFFF to 0.
REQ-028 When i_enable is low, no grant shall be issued, and in-flight tags shall still drain and produce responses.
REQ-029 A falling i_enable takes effect in the same cycle, so no grant is registered for that sample.
REQ-030 The round-robin pointer shall update only on a grant.
REQ-031 With a single requester active continuously, that requester shall be granted every cycle.

Reset
REQ-032 On i_rst_n low, asynchronously: o_gnt=0, o_pipe_valid=0, o_pipe_data=0, all tag valid bits=0, o_rsp_valid=0, o_rsp_id=0, o_busy=0, o_issue_cnt=0, and the pointer set so that requester 0 has first priority.
REQ-033 Reset during operation shall discard all in-flight tags, and no response shall be produced for them after reset release.
REQ-034 Reset release is synchronous to i_clk; the first grant shall be possible at the first edge after release.

Verification
REQ-035 Pra_Delay=4, i_req=0001 for one cycle with payload 0x3C: o_gnt=0001 and o_pipe_valid one cycle later; o_rsp_valid, id=0, 4 cycles after o_pipe_valid.
REQ-036 All 4 requesters held high for 8 cycles: grants 0,1,2,3,0,1,2,3; responses return in the same id order, one per cycle.
REQ-037 i_enable dropped with 3 issues in flight: no further o_gnt; exactly 3 responses; o_busy falls in the cycle after the last response.
REQ-038 i_rst_n pulsed low while 2 issues are in flight: all outputs 0 immediately; no o_rsp_valid within Pra_Delay+2 cycles after release.
REQ-039 0xFFFF consecutive single-requester issues, then 1 more: o_issue_cnt wraps to 0.
REQ-040 Pra_Delay=1, requester 2 continuous: o_rsp_valid high every cycle, starting 2 cycles after the first i_req sample.

Source files
------------

// File: rtl/pipe_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipeline among Pra_Req requesters.
// A {valid,id} tag line follows each issue so the pipeline result returns tagged with its owner.
module pipe_share_arbiter #(
  parameter int Pra_Width = 8,
  parameter int Pra_Delay = 4,
  parameter int Pra_Req   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_enable,
  input  logic [Pra_Req-1:0]           i_req,
  input  logic [Pra_Req*Pra_Width-1:0] i_req_data,
  output logic [Pra_Req-1:0]           o_gnt,
  output logic                         o_pipe_valid,
  output logic [Pra_Width-1:0]         o_pipe_data,
  input  logic [Pra_Width-1:0]         i_pipe_data,
  output logic                         o_rsp_valid,
  output logic [$clog2(Pra_Req)-1:0]   o_rsp_id,
  output logic [Pra_Width-1:0]         o_rsp_data,
  output logic                         o_busy,
  output logic [15:0]                  o_issue_cnt
);
  localparam int IdW = $clog2(Pra_Req);

  logic [IdW-1:0]       r_last;
  logic [Pra_Req-1:0]   r_gnt;
  logic                 r_pipe_valid;
  logic [Pra_Width-1:0] r_pipe_data;
  logic [IdW-1:0]       r_pipe_id;
  logic [15:0]          r_issue_cnt;
  logic [Pra_Delay-1:0] r_tag_vld;
  logic [IdW-1:0]       r_tag_id [Pra_Delay];

  logic                 w_found;
  logic                 w_grant;
  logic [IdW-1:0]       w_win;
  logic [Pra_Req-1:0]   w_win_oh;
  logic [Pra_Width-1:0] w_win_data;
  int                   w_idx;

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_oh   = '0;
    w_win_data = '0;
    w_idx      = 0;
    for (int i = 1; i <= Pra_Req; i++) begin
      w_idx = (int'(r_last) + i) % Pra_Req;
      if (!w_found && i_req[w_idx]) begin
        w_found    = 1'b1;
        w_win      = IdW'(w_idx);
        w_win_oh   = Pra_Req'(1) << w_idx;
        w_win_data = i_req_data[w_idx*Pra_Width +: Pra_Width];
      end
    end
  end

  assign w_grant = i_enable & w_found;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last       <= IdW'(Pra_Req - 1);
      r_gnt        <= '0;
      r_pipe_valid <= 1'b0;
      r_pipe_data  <= '0;
      r_pipe_id    <= '0;
      r_issue_cnt  <= '0;
    end else begin
      r_gnt        <= w_grant ? w_win_oh : '0;
      r_pipe_valid <= w_grant;
      if (w_grant) begin
        r_pipe_data <= w_win_data;
        r_pipe_id   <= w_win;
        r_last      <= w_win;
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end
    end
  end

  // Tag line is fed from the registered issue, so its last stage lines up with the pipeline result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_vld <= '0;
      for (int k = 0; k < Pra_Delay; k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_vld[0] <= r_pipe_valid;
      r_tag_id[0]  <= r_pipe_id;
      for (int k = 1; k < Pra_Delay; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  assign o_gnt        = r_gnt;
  assign o_pipe_valid = r_pipe_valid;
  assign o_pipe_data  = r_pipe_data;
  assign o_rsp_valid  = r_tag_vld[Pra_Delay-1];
  assign o_rsp_id     = r_tag_id[Pra_Delay-1];
  assign o_rsp_data   = i_pipe_data;
  assign o_busy       = (|r_tag_vld) | r_pipe_valid;
  assign o_issue_cnt  = r_issue_cnt;

endmodule
